// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register and ALU operand/forwarding stage.
// Optional RAW forwarding and stall refresh are enabled by defining ID_EX_FORWARD_EN.
module id_ex_operand_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [3:0]        id_alu_ctrl,
    input  logic [REG_AW-1:0] id_rs_addr,
    input  logic [REG_AW-1:0] id_rt_addr,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [15:0]       id_imm,
    input  logic [4:0]        id_shamt,
    input  logic              id_src1_shamt,
    input  logic [1:0]        id_src2_sel,
    input  logic              id_reg_write,
    input  logic [REG_AW-1:0] id_wb_addr,
    input  logic              mem_fwd_valid,
    input  logic [REG_AW-1:0] mem_fwd_addr,
    input  logic [DATA_W-1:0] mem_fwd_data,
    input  logic              wb_fwd_valid,
    input  logic [REG_AW-1:0] wb_fwd_addr,
    input  logic [DATA_W-1:0] wb_fwd_data,
    output logic              ex_valid,
    output logic [3:0]        alu_ctrl,
    output logic [DATA_W-1:0] src1,
    output logic [DATA_W-1:0] src2,
    output logic [DATA_W-1:0] ex_store_data,
    output logic              ex_reg_write,
    output logic [REG_AW-1:0] ex_wb_addr
);

    logic              r_valid;
    logic [3:0]        r_alu_ctrl;
    logic [REG_AW-1:0] r_rs_addr;
    logic [REG_AW-1:0] r_rt_addr;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [15:0]       r_imm;
    logic [4:0]        r_shamt;
    logic              r_src1_shamt;
    logic [1:0]        r_src2_sel;
    logic              r_reg_write;
    logic [REG_AW-1:0] r_wb_addr;

    logic [DATA_W-1:0] w_fwd_rs;
    logic [DATA_W-1:0] w_fwd_rt;

`ifdef ID_EX_FORWARD_EN
    // EX/MEM is the younger producer, so it takes priority over MEM/WB; r0 is never forwarded.
    always_comb begin
        w_fwd_rs = r_rs_data;
        if (r_rs_addr != '0 && mem_fwd_valid && mem_fwd_addr == r_rs_addr)
            w_fwd_rs = mem_fwd_data;
        else if (r_rs_addr != '0 && wb_fwd_valid && wb_fwd_addr == r_rs_addr)
            w_fwd_rs = wb_fwd_data;
    end

    always_comb begin
        w_fwd_rt = r_rt_data;
        if (r_rt_addr != '0 && mem_fwd_valid && mem_fwd_addr == r_rt_addr)
            w_fwd_rt = mem_fwd_data;
        else if (r_rt_addr != '0 && wb_fwd_valid && wb_fwd_addr == r_rt_addr)
            w_fwd_rt = wb_fwd_data;
    end
`else
    // Without forwarding the hazard unit stalls until writeback, so the bypass inputs are don't-cares.
    logic w_unused_fwd;
    assign w_unused_fwd = ^{mem_fwd_valid, mem_fwd_addr, mem_fwd_data,
                            wb_fwd_valid, wb_fwd_addr, wb_fwd_data};
    assign w_fwd_rs = r_rs_data;
    assign w_fwd_rt = r_rt_data;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset || flush) begin
            r_valid      <= 1'b0;
            r_alu_ctrl   <= '0;
            r_rs_addr    <= '0;
            r_rt_addr    <= '0;
            r_rs_data    <= '0;
            r_rt_data    <= '0;
            r_imm        <= '0;
            r_shamt      <= '0;
            r_src1_shamt <= 1'b0;
            r_src2_sel   <= '0;
            r_reg_write  <= 1'b0;
            r_wb_addr    <= '0;
        end else if (stall) begin
`ifdef ID_EX_FORWARD_EN
            // Capture bypassed values so a producer retiring out of WB mid-stall is not lost.
            r_rs_data <= w_fwd_rs;
            r_rt_data <= w_fwd_rt;
`endif
        end else begin
            r_valid      <= id_valid;
            r_alu_ctrl   <= id_alu_ctrl;
            r_rs_addr    <= id_rs_addr;
            r_rt_addr    <= id_rt_addr;
            r_rs_data    <= id_rs_data;
            r_rt_data    <= id_rt_data;
            r_imm        <= id_imm;
            r_shamt      <= id_shamt;
            r_src1_shamt <= id_src1_shamt;
            r_src2_sel   <= id_src2_sel;
            r_reg_write  <= id_reg_write;
            r_wb_addr    <= id_wb_addr;
        end
    end

    always_comb begin
        src1 = r_src1_shamt ? {{(DATA_W-5){1'b0}}, r_shamt} : w_fwd_rs;
        case (r_src2_sel)
            2'b00:   src2 = w_fwd_rt;
            2'b01:   src2 = {{(DATA_W-16){r_imm[15]}}, r_imm};
            2'b10:   src2 = {{(DATA_W-16){1'b0}}, r_imm};
            default: src2 = '0;
        endcase
    end

    assign ex_valid      = r_valid;
    assign alu_ctrl      = r_alu_ctrl;
    assign ex_store_data = w_fwd_rt;
    assign ex_reg_write  = r_reg_write & r_valid;
    assign ex_wb_addr    = r_wb_addr;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage; expectations follow whether ID_EX_FORWARD_EN is defined.
module tb_id_ex_operand_stage;

`ifdef ID_EX_FORWARD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [3:0]  id_alu_ctrl;
    logic [4:0]  id_rs_addr;
    logic [4:0]  id_rt_addr;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [15:0] id_imm;
    logic [4:0]  id_shamt;
    logic        id_src1_shamt;
    logic [1:0]  id_src2_sel;
    logic        id_reg_write;
    logic [4:0]  id_wb_addr;
    logic        mem_fwd_valid;
    logic [4:0]  mem_fwd_addr;
    logic [31:0] mem_fwd_data;
    logic        wb_fwd_valid;
    logic [4:0]  wb_fwd_addr;
    logic [31:0] wb_fwd_data;
    logic        ex_valid;
    logic [3:0]  alu_ctrl;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] ex_store_data;
    logic        ex_reg_write;
    logic [4:0]  ex_wb_addr;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    id_ex_operand_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_alu_ctrl(id_alu_ctrl),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_shamt(id_shamt),
        .id_src1_shamt(id_src1_shamt), .id_src2_sel(id_src2_sel),
        .id_reg_write(id_reg_write), .id_wb_addr(id_wb_addr),
        .mem_fwd_valid(mem_fwd_valid), .mem_fwd_addr(mem_fwd_addr), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_valid(wb_fwd_valid), .wb_fwd_addr(wb_fwd_addr), .wb_fwd_data(wb_fwd_data),
        .ex_valid(ex_valid), .alu_ctrl(alu_ctrl), .src1(src1), .src2(src2),
        .ex_store_data(ex_store_data), .ex_reg_write(ex_reg_write), .ex_wb_addr(ex_wb_addr)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".ex_valid"},      32'(ex_valid),     32'h0);
        check({tag, ".alu_ctrl"},      32'(alu_ctrl),     32'h0);
        check({tag, ".src1"},          src1,              32'h0);
        check({tag, ".src2"},          src2,              32'h0);
        check({tag, ".ex_store_data"}, ex_store_data,     32'h0);
        check({tag, ".ex_reg_write"},  32'(ex_reg_write), 32'h0);
        check({tag, ".ex_wb_addr"},    32'(ex_wb_addr),   32'h0);
    endtask

    // advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_instr(input logic v, input logic [3:0] alu,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic [31:0] rsd, input logic [31:0] rtd,
                               input logic [15:0] imm, input logic [4:0] sh,
                               input logic s1sh, input logic [1:0] s2sel,
                               input logic rw, input logic [4:0] wb);
        id_valid = v;     id_alu_ctrl = alu;
        id_rs_addr = rs;  id_rt_addr = rt;
        id_rs_data = rsd; id_rt_data = rtd;
        id_imm = imm;     id_shamt = sh;
        id_src1_shamt = s1sh; id_src2_sel = s2sel;
        id_reg_write = rw;    id_wb_addr = wb;
    endtask

    task automatic drive_fwd(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                             input logic wv, input logic [4:0] wa, input logic [31:0] wd);
        mem_fwd_valid = mv; mem_fwd_addr = ma; mem_fwd_data = md;
        wb_fwd_valid  = wv; wb_fwd_addr  = wa; wb_fwd_data  = wd;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        drive_instr(1'b0, 4'h0, 5'd0, 5'd0, 32'h0, 32'h0, 16'h0, 5'd0, 1'b0, 2'b00, 1'b0, 5'd0);
        drive_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        step();
        step();
        check_all_zero("reset");
        reset = 1'b0;

        // ADDI r3 = r1 + sext(FFFE)
        drive_instr(1'b1, 4'h2, 5'd1, 5'd0, 32'h10, 32'h0, 16'hFFFE, 5'd0, 1'b0, 2'b01, 1'b1, 5'd3);
        step();
        check("addi.ex_valid",     32'(ex_valid),     32'h1);
        check("addi.alu_ctrl",     32'(alu_ctrl),     32'h2);
        check("addi.src1",         src1,              32'h10);
        check("addi.src2",         src2,              32'hFFFFFFFE);
        check("addi.ex_reg_write", 32'(ex_reg_write), 32'h1);
        check("addi.ex_wb_addr",   32'(ex_wb_addr),   32'h3);

        // ORI-style zero-extended immediate, reserved alu code passes through
        drive_instr(1'b1, 4'hF, 5'd1, 5'd0, 32'h1, 32'h0, 16'h8001, 5'd0, 1'b0, 2'b10, 1'b0, 5'd5);
        step();
        check("zext.src2",         src2,              32'h00008001);
        check("zext.alu_ctrl",     32'(alu_ctrl),     32'hF);
        check("zext.ex_reg_write", 32'(ex_reg_write), 32'h0);

        // forwarding priority on rs=4, src2 forced to zero
        drive_instr(1'b1, 4'h1, 5'd4, 5'd0, 32'h1111, 32'h0, 16'h0, 5'd0, 1'b0, 2'b11, 1'b1, 5'd6);
        step();
        drive_fwd(1'b1, 5'd4, 32'hAAAA, 1'b1, 5'd4, 32'hBBBB);
        #1;
        check("fwd.mem_prio", src1, FWD_EN ? 32'hAAAA : 32'h1111);
        check("fwd.src2_zero", src2, 32'h0);
        mem_fwd_valid = 1'b0;
        #1;
        check("fwd.wb_only", src1, FWD_EN ? 32'hBBBB : 32'h1111);
        mem_fwd_addr = 5'd9; mem_fwd_valid = 1'b1;
        #1;
        check("fwd.mem_addr_miss", src1, FWD_EN ? 32'hBBBB : 32'h1111);

        // rs=0 must never be forwarded
        drive_fwd(1'b1, 5'd0, 32'hAAAA, 1'b1, 5'd0, 32'hBBBB);
        drive_instr(1'b1, 4'h1, 5'd0, 5'd0, 32'h2222, 32'h0, 16'h0, 5'd0, 1'b0, 2'b11, 1'b1, 5'd6);
        step();
        check("fwd.r0_stored", src1, 32'h2222);

        // SLL by 5, rt=7 forwarded from WB
        drive_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h3);
        drive_instr(1'b1, 4'h8, 5'd0, 5'd7, 32'h0, 32'h1, 16'h0, 5'd5, 1'b1, 2'b00, 1'b1, 5'd8);
        step();
        check("sll.src1",       src1,          32'h5);
        check("sll.src2",       src2,          FWD_EN ? 32'h3 : 32'h1);
        check("sll.store_data", ex_store_data, FWD_EN ? 32'h3 : 32'h1);

        // stall refresh: rs=2 stored 0x20, WB retires r2=0x55 only during first stall cycle
        drive_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        drive_instr(1'b1, 4'h3, 5'd2, 5'd0, 32'h20, 32'h0, 16'h0, 5'd0, 1'b0, 2'b11, 1'b1, 5'd10);
        step();
        exp_q.push_back(FWD_EN ? 32'h55 : 32'h20);
        exp_q.push_back(FWD_EN ? 32'h55 : 32'h20);
        stall = 1'b1;
        drive_instr(1'b1, 4'h4, 5'd9, 5'd0, 32'h99, 32'h0, 16'h0, 5'd0, 1'b0, 2'b11, 1'b1, 5'd11);
        drive_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'h55);
        #1;
        check("stall.cycle1", src1, exp_q.pop_front());
        step();
        wb_fwd_valid = 1'b0;
        #1;
        check("stall.cycle2", src1, exp_q.pop_front());
        check("stall.hold_wb", 32'(ex_wb_addr), 32'hA);
        step();
        stall = 1'b0;
        step();
        check("release.src1",     src1,            32'h99);
        check("release.wb_addr",  32'(ex_wb_addr), 32'hB);
        check("release.alu_ctrl", 32'(alu_ctrl),   32'h4);

        // stall and flush together: flush wins
        stall = 1'b1; flush = 1'b1;
        step();
        stall = 1'b0; flush = 1'b0;
        check_all_zero("stall_flush");

        // asynchronous reset mid-operation
        drive_instr(1'b1, 4'h6, 5'd1, 5'd0, 32'h1234, 32'h0, 16'h7, 5'd0, 1'b0, 2'b01, 1'b1, 5'd12);
        step();
        check("pre_reset.ex_valid", 32'(ex_valid), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        step();
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
